f_predictpc: RTL

F_PREDICTPC -- requirements
Module: f_predictpc

---
 rtl/f_predictpc_pkg.sv | 27 ++
 rtl/f_predictpc_if.sv | 26 ++
 rtl/f_predictpc_btb_ram.sv | 23 ++
 rtl/f_predictpc.sv | 113 +++++++++++
 4 files changed

// File: rtl/f_predictpc_pkg.sv
// Shared fetch-prediction definitions: PC/index widths, BTB entry layout, FSM states.
// Also imported by the execute-stage BTB writer so both sides agree on the entry format.
package f_predictpc_pkg;

  localparam int unsigned PC_W      = 13;
  localparam int unsigned IDX_W     = 11;
  localparam int unsigned TAG_W     = PC_W - IDX_W;
  localparam int unsigned ENTRY_W   = 16;

  localparam int unsigned VALID_BIT = 15;
  localparam int unsigned TAG_HI    = 14;
  localparam int unsigned TAG_LO    = 13;
  localparam int unsigned TARGET_HI = 12;
  localparam int unsigned TARGET_LO = 0;

  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] tag;
    logic [PC_W-1:0]  target;
  } btb_entry_t;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/f_predictpc_if.sv
// Fetch/execute bus of the PC predictor: redirect, BTB update and fetch results.
interface f_predictpc_if;
  import f_predictpc_pkg::*;

  logic               stall;
  logic               fail_predict;
  logic [PC_W-1:0]    true_pc;
  logic               wen;
  logic [IDX_W-1:0]   w_addr;
  logic [ENTRY_W-1:0] w_data;
  logic [PC_W-1:0]    pc;
  logic [PC_W-1:0]    pc_predicted;
  logic               hit;
  logic               ready;

  modport master (
    output stall, fail_predict, true_pc, wen, w_addr, w_data,
    input  pc, pc_predicted, hit, ready
  );

  modport slave (
    input  stall, fail_predict, true_pc, wen, w_addr, w_data,
    output pc, pc_predicted, hit, ready
  );

endinterface

// File: rtl/f_predictpc_btb_ram.sv
// BTB storage: simple dual-port RAM, one write port and one registered read port, no reset.
module f_predictpc_btb_ram #(
  parameter int unsigned DEPTH = 2048,
  parameter int unsigned AW    = 11,
  parameter int unsigned DW    = 16
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [DEPTH];

  // read returns old contents on a same-address write; the caller bypasses
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/f_predictpc.sv
// Fetch-stage next-PC predictor: BTB lookup aligned to pc, redirect/stall priority,
// and a power-up pass that clears every BTB entry before fetch starts.
module f_predictpc
  import f_predictpc_pkg::*;
#(
  parameter int unsigned     ENTRIES  = 2048,
  parameter logic [PC_W-1:0] RESET_PC = 13'd0
) (
  input  logic         clk,
  input  logic         rst_n,
  f_predictpc_if.slave bus
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ENTRIES - 1);

  fetch_state_e       state;
  fetch_state_e       state_next;
  logic [IDX_W-1:0]   init_cnt;
  logic [PC_W-1:0]    pc_q;
  logic               ready_q;
  logic               byp_q;
  btb_entry_t         byp_data_q;
  logic [ENTRY_W-1:0] ram_rdata;

  logic               run_c;
  logic               ram_we_c;
  logic [IDX_W-1:0]   ram_waddr_c;
  logic [ENTRY_W-1:0] ram_wdata_c;
  logic [IDX_W-1:0]   ram_raddr_c;
  logic [PC_W-1:0]    next_pc_c;
  logic [PC_W-1:0]    pred_c;
  logic               hit_c;
  btb_entry_t         entry_c;

  // state register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_INIT;
    else        state <= state_next;
  end

  // next state: leave INIT after clearing the last index, never return except by reset
  always_comb begin
    state_next = state;
    case (state)
      ST_INIT: if (init_cnt == LAST_IDX) state_next = ST_RUN;
      ST_RUN:  state_next = ST_RUN;
      default: state_next = ST_INIT;
    endcase
  end

  // per-state control: INIT owns the write port and pins the fetch address
  always_comb begin
    run_c       = 1'b0;
    ram_we_c    = 1'b1;
    ram_waddr_c = init_cnt;
    ram_wdata_c = '0;
    next_pc_c   = RESET_PC;
    case (state)
      ST_RUN: begin
        run_c       = 1'b1;
        ram_we_c    = bus.wen;
        ram_waddr_c = bus.w_addr;
        ram_wdata_c = bus.w_data;
        if (bus.fail_predict) next_pc_c = bus.true_pc;
        else if (bus.stall)   next_pc_c = pc_q;
        else                  next_pc_c = pred_c;
      end
      default: ;
    endcase
  end

  assign ram_raddr_c = next_pc_c[IDX_W-1:0];

  // bypass register substitutes same-cycle write data (or zero during INIT/reset)
  assign entry_c = byp_q ? byp_data_q : btb_entry_t'(ram_rdata);
  assign hit_c   = entry_c.valid && (entry_c.tag == pc_q[PC_W-1:IDX_W]);
  assign pred_c  = hit_c ? entry_c.target : pc_q + PC_W'(1);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      init_cnt   <= '0;
      pc_q       <= RESET_PC;
      ready_q    <= 1'b0;
      byp_q      <= 1'b1;
      byp_data_q <= '0;
    end else begin
      if (!run_c) init_cnt <= init_cnt + IDX_W'(1);
      pc_q       <= next_pc_c;
      ready_q    <= (state_next == ST_RUN);
      byp_q      <= !run_c || (ram_we_c && (ram_waddr_c == ram_raddr_c));
      byp_data_q <= run_c ? btb_entry_t'(ram_wdata_c) : '0;
    end
  end

  f_predictpc_btb_ram #(
    .DEPTH (ENTRIES),
    .AW    (IDX_W),
    .DW    (ENTRY_W)
  ) btb_ram (
    .clk   (clk),
    .we    (ram_we_c),
    .waddr (ram_waddr_c),
    .wdata (ram_wdata_c),
    .raddr (ram_raddr_c),
    .rdata (ram_rdata)
  );

  assign bus.pc           = pc_q;
  assign bus.pc_predicted = pred_c;
  assign bus.hit          = hit_c;
  assign bus.ready        = ready_q;

endmodule
